// File: rtl/kb_disp_ctrl_if.sv
// Byte stream from the PS/2 receiver into the key sequencer, and the
// key/display controls from the sequencer to the seven-segment driver.
interface kb_disp_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       ps2dis_data;
    logic             ps2dis_recFlag;
    logic [7:0]       key_code;
    logic             key_ext;
    logic [7:0]       ascii;
    logic [CNT_W-1:0] key_cnt;
    logic             key_down;
    logic             key_event;
    logic             disp_blank;

    modport master (
        output ps2dis_data, ps2dis_recFlag,
        input  key_code, key_ext, ascii, key_cnt, key_down, key_event, disp_blank
    );

    modport slave (
        input  ps2dis_data, ps2dis_recFlag,
        output key_code, key_ext, ascii, key_cnt, key_down, key_event, disp_blank
    );
endinterface

// File: rtl/kb_disp_ctrl.sv
// PS/2 set-2 scan-code sequencer: decodes make/break/extended prefixes, tracks the
// held key, suppresses typematic repeats, counts presses and drives display controls.
module kb_disp_ctrl #(
    parameter int CNT_W     = 8,
    parameter bit DROP_CTRL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    kb_disp_ctrl_if.slave bus
);

    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;
    localparam logic [7:0] B_BAT = 8'hAA;
    localparam logic [7:0] B_ACK = 8'hFA;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_WAIT    = 5'b00010,
        S_EXT     = 5'b00100,
        S_BRK     = 5'b01000,
        S_EXT_BRK = 5'b10000
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       key_code_q;
    logic             key_ext_q;
    logic [7:0]       ascii_q;
    logic [CNT_W-1:0] key_cnt_q;
    logic             key_down_q;
    logic             key_event_q;
    logic             disp_blank_q;

    logic             do_make_d;
    logic             make_ext_d;
    logic             do_release_d;

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_is_prefix;
    logic             rx_is_ctrl;
    logic             held_plain;
    logic             held_ext;

    // Set-2 scan code to ASCII for letters, main-row digits and space.
    function automatic logic [7:0] ascii_lut(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
            8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
            8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
            8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;  8'h25: a = 8'h34;
            8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
            8'h46: a = 8'h39;  8'h45: a = 8'h30;
            8'h29: a = 8'h20;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    assign rx_byte      = bus.ps2dis_data;
    assign rx_valid     = bus.ps2dis_recFlag;
    assign rx_is_prefix = (rx_byte == B_EXT) || (rx_byte == B_BRK);
    assign rx_is_ctrl   = (rx_byte == B_BAT) || (rx_byte == B_ACK);
    // A held key only matches a code of the same extended-ness.
    assign held_plain   = key_down_q && !key_ext_q && (rx_byte == key_code_q);
    assign held_ext     = key_down_q &&  key_ext_q && (rx_byte == key_code_q);

    // Protocol decode: next state plus make/release strobes for this byte.
    always_comb begin
        state_d      = state_q;
        do_make_d    = 1'b0;
        make_ext_d   = 1'b0;
        do_release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!rx_valid) begin
                    state_d = S_WAIT;
                end else if (rx_byte == B_EXT) begin
                    state_d = S_EXT;
                end else if (rx_byte == B_BRK) begin
                    state_d = S_BRK;
                end else if (DROP_CTRL && rx_is_ctrl) begin
                    state_d = S_WAIT;
                end else begin
                    do_make_d = !held_plain;
                end
            end
            S_EXT: begin
                if (!rx_valid) begin
                    state_d = S_EXT;
                end else if (rx_byte == B_BRK) begin
                    state_d = S_EXT_BRK;
                end else if (rx_byte == B_EXT) begin
                    state_d = S_EXT;
                end else begin
                    do_make_d  = !held_ext;
                    make_ext_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_BRK: begin
                if (rx_valid) begin
                    do_release_d = !rx_is_prefix && held_plain;
                    state_d      = S_WAIT;
                end else begin
                    state_d = S_BRK;
                end
            end
            S_EXT_BRK: begin
                if (rx_valid) begin
                    do_release_d = !rx_is_prefix && held_ext;
                    state_d      = S_WAIT;
                end else begin
                    state_d = S_EXT_BRK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and all registered key/display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            ascii_q      <= 8'h00;
            key_cnt_q    <= {CNT_W{1'b0}};
            key_down_q   <= 1'b0;
            key_event_q  <= 1'b0;
            disp_blank_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            key_event_q <= do_make_d;
            if (do_make_d) begin
                key_code_q   <= rx_byte;
                key_ext_q    <= make_ext_d;
                ascii_q      <= make_ext_d ? 8'h00 : ascii_lut(rx_byte);
                key_cnt_q    <= key_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                key_down_q   <= 1'b1;
                disp_blank_q <= 1'b0;
            end else if (do_release_d) begin
                key_down_q   <= 1'b0;
                disp_blank_q <= 1'b1;
            end else begin
                key_down_q   <= key_down_q;
                disp_blank_q <= disp_blank_q;
            end
        end
    end

    assign bus.key_code   = key_code_q;
    assign bus.key_ext    = key_ext_q;
    assign bus.ascii      = ascii_q;
    assign bus.key_cnt    = key_cnt_q;
    assign bus.key_down   = key_down_q;
    assign bus.key_event  = key_event_q;
    assign bus.disp_blank = disp_blank_q;

endmodule

// File: tb/tb_kb_disp_ctrl.sv
// Self-checking bench for kb_disp_ctrl: directed protocol scenarios and random byte
// streams compared every cycle against a prefix-flag based key model.
module tb_kb_disp_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ev_seen;

    kb_disp_ctrl_if #(.CNT_W(8)) bus ();

    kb_disp_ctrl #(.CNT_W(8), .DROP_CTRL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending-prefix flags and the held key
    bit         idle_p, ext_p, brk_p;
    logic [7:0] m_code, m_ascii;
    bit         m_ext, m_down, m_event, m_blank;
    int         m_cnt;

    byte unsigned letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
    byte unsigned digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
    byte unsigned pool [8] = '{8'h1C, 8'h32, 8'h75, 8'h45, 8'h29, 8'h16, 8'h1A, 8'h6B};

    function automatic logic [7:0] model_ascii(input logic [7:0] c);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 26; i++) if (letter_sc[i] == c) r = 8'(8'h41 + i);
        for (int i = 0; i < 10; i++) if (digit_sc[i] == c) r = 8'(8'h30 + i);
        if (c == 8'h29) r = 8'h20;
        return r;
    endfunction

    task automatic model_reset();
        idle_p = 1'b1; ext_p = 1'b0; brk_p = 1'b0;
        m_code = 8'h00; m_ascii = 8'h00; m_ext = 1'b0; m_down = 1'b0;
        m_event = 1'b0; m_blank = 1'b1; m_cnt = 0;
    endtask

    task automatic model_step(input bit f, input logic [7:0] b);
        m_event = 1'b0;
        if (idle_p) begin
            idle_p = 1'b0;
        end else if (f) begin
            if (brk_p) begin
                if (b != 8'hE0 && b != 8'hF0 && m_down && m_ext == ext_p && m_code == b) begin
                    m_down  = 1'b0;
                    m_blank = 1'b1;
                end
                brk_p = 1'b0;
                ext_p = 1'b0;
            end else if (b == 8'hF0) begin
                brk_p = 1'b1;
            end else if (b == 8'hE0) begin
                ext_p = 1'b1;
            end else if (!ext_p && (b == 8'hAA || b == 8'hFA)) begin
                ext_p = 1'b0;
            end else begin
                if (!(m_down && m_ext == ext_p && m_code == b)) begin
                    m_code  = b;
                    m_ext   = ext_p;
                    m_ascii = ext_p ? 8'h00 : model_ascii(b);
                    m_down  = 1'b1;
                    m_blank = 1'b0;
                    m_cnt   = (m_cnt + 1) % 256;
                    m_event = 1'b1;
                end
                ext_p = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("key_code",   32'(bus.key_code),   32'(m_code));
        chk("key_ext",    32'(bus.key_ext),    32'(m_ext));
        chk("ascii",      32'(bus.ascii),      32'(m_ascii));
        chk("key_cnt",    32'(bus.key_cnt),    32'(m_cnt));
        chk("key_down",   32'(bus.key_down),   32'(m_down));
        chk("key_event",  32'(bus.key_event),  32'(m_event));
        chk("disp_blank", 32'(bus.disp_blank), 32'(m_blank));
    endtask

    // One clock cycle of stimulus (driven from a negedge), then model update and compare.
    task automatic tick(input bit f, input logic [7:0] b);
        bus.ps2dis_recFlag = f;
        bus.ps2dis_data    = f ? b : 8'($urandom);
        @(negedge clk);
        bus.ps2dis_recFlag = 1'b0;
        model_step(f, b);
        cmp_all();
        if (bus.key_event) ev_seen++;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        cmp_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int ev0;
        logic [7:0] c;
        int r;
        checks = 0; errors = 0; ev_seen = 0;
        rst = 1'b1;
        bus.ps2dis_recFlag = 1'b0;
        bus.ps2dis_data    = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        cmp_all();
        rst = 1'b0;

        // Basic make/break of 'A'
        tick(1'b0, 8'h00);
        send(8'h1C);
        chk("a_code", 32'(bus.key_code), 32'h1C);
        chk("a_ascii", 32'(bus.ascii), 32'h41);
        chk("a_cnt", 32'(bus.key_cnt), 32'd1);
        chk("a_event", 32'(bus.key_event), 32'd1);
        tick(1'b0, 8'h00);
        send(8'hF0);
        send(8'h1C);
        chk("a_down", 32'(bus.key_down), 32'd0);
        chk("a_blank", 32'(bus.disp_blank), 32'd1);

        // Typematic repeats count once
        async_reset();
        tick(1'b0, 8'h00);
        ev0 = ev_seen;
        repeat (5) send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        chk("tm_cnt", 32'(bus.key_cnt), 32'd1);
        chk("tm_events", 32'(ev_seen - ev0), 32'd1);
        send(8'h32);
        chk("tm_cnt2", 32'(bus.key_cnt), 32'd2);
        chk("tm_ascii", 32'(bus.ascii), 32'h42);

        // Extended key press/release
        send(8'hE0); send(8'h75);
        chk("ext_flag", 32'(bus.key_ext), 32'd1);
        chk("ext_code", 32'(bus.key_code), 32'h75);
        chk("ext_ascii", 32'(bus.ascii), 32'h00);
        send(8'hE0); send(8'hF0);
        chk("ext_held", 32'(bus.key_down), 32'd1);
        send(8'h75);
        chk("ext_rel", 32'(bus.key_down), 32'd0);

        // Mismatched break, protocol error, control byte
        send(8'h1C);
        send(8'hF0); send(8'h32);
        chk("mm_held", 32'(bus.key_down), 32'd1);
        send(8'hF0); send(8'hE0);
        send(8'hAA);
        send(8'h32);
        chk("err_make", 32'(bus.key_code), 32'h32);

        // Counter wrap over 256 presses
        async_reset();
        tick(1'b0, 8'h00);
        ev0 = ev_seen;
        for (int i = 0; i < 256; i++) begin
            c = pool[$urandom_range(0, 7)];
            send(c); send(8'hF0); send(c);
        end
        chk("wrap_cnt", 32'(bus.key_cnt), 32'd0);
        chk("wrap_events", 32'(ev_seen - ev0), 32'd256);

        // Reset between break prefix and its byte; a pulse during idle is dropped
        send(8'h1C); send(8'hF0);
        async_reset();
        send(8'h45);
        chk("idle_drop", 32'(bus.key_cnt), 32'd0);
        send(8'h45);
        chk("rst_ascii", 32'(bus.ascii), 32'h30);
        chk("rst_cnt", 32'(bus.key_cnt), 32'd1);

        // Random byte streams with gaps
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      c = 8'hE0;
            else if (r < 25) c = 8'hF0;
            else if (r < 28) c = 8'hAA;
            else if (r < 30) c = 8'hFA;
            else if (r < 85) c = pool[$urandom_range(0, 7)];
            else             c = 8'($urandom);
            send(c);
            repeat ($urandom_range(0, 2)) tick(1'b0, 8'h00);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kb_disp_ctrl.md
Name: kb_disp_ctrl

Overview:
Sequencer between the PS/2 receiver and the seven-segment display driver. Consumes the PS/2 set-2 byte stream (one byte per valid pulse) and runs a scan-code protocol FSM covering make, break (0xF0) and extended (0xE0) prefixes. Tracks the currently held key, suppresses typematic repeats and counts distinct presses. Drives registered hex-nibble and blank controls to the display block.

Parameters:
CNT_W, 8, width of the key-press counter (wraps modulo 2^CNT_W)
DROP_CTRL, 1, when 1, bytes 0xAA (BAT) and 0xFA (ACK) in S_WAIT are discarded without effect

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
ps2dis_data  input  8  received PS/2 byte, valid only while ps2dis_recFlag=1
ps2dis_recFlag  input  1  one-cycle pulse per received byte
key_code  output  8  scan code of held/last key (without prefix)
key_ext  output  1  1 if key_code was E0-prefixed
ascii  output  8  ASCII of key_code, 0x00 if unmapped or key_ext=1
key_cnt  output  CNT_W  number of distinct presses since reset
key_down  output  1  a key is currently held
key_event  output  1  one-cycle pulse on each counted press
disp_blank  output  1  1 = display digits off (no key held)

Behaviour:
- All outputs registered; reset values: key_code=0, key_ext=0, ascii=0, key_cnt=0, key_down=0, key_event=0, disp_blank=1; FSM to S_IDLE.
- FSM states (one-hot): S_IDLE, S_WAIT, S_EXT, S_BRK, S_EXT_BRK. Transitions occur only on cycles with ps2dis_recFlag=1, except S_IDLE.
- S_IDLE: unconditionally to S_WAIT next cycle; a byte pulse in this cycle is dropped.
- S_WAIT: 0xE0 -> S_EXT; 0xF0 -> S_BRK; 0xAA/0xFA with DROP_CTRL=1 -> stay, no effect; other byte -> make(byte, ext=0), stay.
- S_EXT: 0xF0 -> S_EXT_BRK; 0xE0 -> stay; other -> make(byte, ext=1), -> S_WAIT.
- S_BRK: any byte b -> break(b, ext=0), -> S_WAIT. S_EXT_BRK: any b -> break(b, ext=1), -> S_WAIT. A prefix byte (0xE0/0xF0) received in S_BRK/S_EXT_BRK is a protocol error: drop, -> S_WAIT, outputs unchanged.
- make(c,e): if key_down=1 and {e,c}=={key_ext,key_code}: typematic repeat, no output change. Otherwise latch key_code=c, key_ext=e, ascii=lookup, key_down=1, disp_blank=0, key_cnt+1 (wraps max->0), key_event=1 for exactly one cycle. Latency: outputs valid the cycle after the recFlag edge.
- break(c,e): if key_down=1 and matches held {ext,code}: key_down=0, disp_blank=1; key_code/ascii/key_cnt retained. Non-matching break ignored.
- key_event is 0 in every cycle not following a counted make.
- ascii lookup (set 2): letters A-Z -> 0x41-0x5A (e.g. 0x1C->0x41, 0x32->0x42, 0x1A->0x5A); main-row digits 1-9,0 (0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45) -> 0x31-0x39,0x30; 0x29->0x20; all else 0x00.
- Reset asserted mid-sequence (e.g. after 0xF0) returns FSM to S_IDLE and all outputs to reset values immediately (asynchronous).
- ps2dis_data ignored while ps2dis_recFlag=0.

Test Plan:
- Reset release, bytes 0x1C then 0xF0,0x1C -> key_code=0x1C, ascii=0x41, key_cnt=1, one key_event pulse, key_down 1 then 0, disp_blank 0 then 1.
- Typematic: 0x1C x5 then 0xF0,0x1C -> key_cnt=1, single key_event; then 0x32 -> key_cnt=2, ascii=0x42.
- Extended: 0xE0,0x75 then 0xE0,0xF0,0x75 -> key_ext=1, key_code=0x75, ascii=0x00, key_down clears only after full E0 F0 75.
- Mismatched break and error: held 0x1C, send 0xF0,0x32 -> key_down stays 1; send 0xF0,0xE0 -> FSM back to S_WAIT, outputs unchanged; 0xAA in S_WAIT -> no effect.
- Wrap: 256 distinct make/break pairs with CNT_W=8 -> key_cnt returns to 0x00, 256 key_event pulses.
- Async reset pulse between 0xF0 and its break byte -> all outputs at reset values within same cycle; next 0x45 after S_IDLE -> ascii=0x30, key_cnt=1.
